// File: rtl/debug_pkg.sv
// Shared definitions for the debug_port bus peripheral: register offsets,
// transfer size encodings, STATUS bit positions and byte-lane helpers.
package debug_pkg;

    localparam logic [31:0] OFS_STATUS  = 32'h80;
    localparam logic [31:0] OFS_CHANGED = 32'h84;
    localparam logic [31:0] OFS_TXDATA  = 32'h88;
    localparam logic [31:0] OFS_CYCLE   = 32'h8C;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int STAT_BOOT     = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_OVERFLOW = 3;
    localparam int STAT_LEVEL_LO = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_OUT,
        REG_IN,
        REG_STATUS,
        REG_CHANGED,
        REG_TXDATA,
        REG_CYCLE
    } regSel_e;

    // Lanes past byte 3 fall off the top, so a half at offset 3 touches one byte.
    function automatic logic [3:0] byteEnables(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            SIZE_BYTE: base = 4'b0001;
            SIZE_HALF: base = 4'b0011;
            default:   base = 4'b1111;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] byteMask(input logic [3:0] be);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/debug_fifo.sv
// Synchronous byte FIFO feeding the debug console stream; head is shown
// combinationally so the consumer sees data the cycle it becomes valid.
module debug_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW:0]      level_q, level_d;
    logic             doPush, doPop;

    // A push into a full FIFO is still taken when a pop frees the head slot.
    always_comb begin
        empty_o = (level_q == '0);
        full_o  = (level_q == (PW+1)'(DEPTH));
        doPop   = pop_i & ~empty_o;
        doPush  = push_i & (~full_o | doPop);
        wrPtr_d = doPush ? wrPtr_q + PW'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + PW'(1) : rdPtr_q;
        level_d = level_q;
        if (doPush && !doPop) begin
            level_d = level_q + (PW+1)'(1);
        end else if (doPop && !doPush) begin
            level_d = level_q - (PW+1)'(1);
        end
        head_o  = empty_o ? '0 : mem_q[rdPtr_q];
        level_o = level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/debug_port.sv
// Bring-up debug peripheral on the valid/ready data bus: NCH out/in register
// pairs, sticky input change flags, a cycle counter and a console TX FIFO.
module debug_port
    import debug_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boot,
    input  logic [32*NCH-1:0]   in_vec,
    output logic [32*NCH-1:0]   out_vec,
    input  logic                valid,
    input  logic                write,
    input  logic [31:0]         addr,
    input  logic [1:0]          size,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [31:0]       out_q [NCH];
    logic [31:0]       out_d [NCH];
    logic [32*NCH-1:0] inPrev_q;
    logic [NCH-1:0]    changed_q, changed_d, changeNow;
    logic              overflow_q, overflow_d;
    logic [31:0]       cycle_q, cycle_d;
    logic              ready_q, ready_d;
    logic [31:0]       rdata_q, rdata_d;

    regSel_e     sel;
    logic [31:0] offset;
    logic [3:0]  chIdx;
    logic [31:0] chOut, chIn, statusWord, changedWord, regWord, rdWord;
    logic [31:0] lvlWide;
    logic        accept, wrEn;
    logic [3:0]  be;
    logic [31:0] laneData, laneMask, w1c;

    logic            fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [7:0]      fifoHead;
    logic [LW-1:0]   fifoLevel;
    logic            unusedAddr;

    assign unusedAddr = ^addr;

    // Only addr[AW-1:2] takes part in decode; channel slots occupy 0x00..0x7C.
    always_comb begin
        offset         = '0;
        offset[AW-1:2] = addr[AW-1:2];
        chIdx          = offset[6:3];
        sel            = REG_NONE;
        if (offset[31:7] == '0) begin
            if ({28'd0, chIdx} < 32'(NCH)) begin
                sel = offset[2] ? REG_IN : REG_OUT;
            end
        end else begin
            case (offset)
                OFS_STATUS:  sel = REG_STATUS;
                OFS_CHANGED: sel = REG_CHANGED;
                OFS_TXDATA:  sel = REG_TXDATA;
                OFS_CYCLE:   sel = REG_CYCLE;
                default:     sel = REG_NONE;
            endcase
        end
    end

    always_comb begin
        chOut = '0;
        chIn  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (chIdx == 4'(i)) begin
                chOut = out_q[i];
                chIn  = in_vec[32*i +: 32];
            end
        end
        lvlWide    = 32'(fifoLevel);
        statusWord = '0;
        statusWord[STAT_BOOT]            = boot;
        statusWord[STAT_TX_EMPTY]        = fifoEmpty;
        statusWord[STAT_TX_FULL]         = fifoFull;
        statusWord[STAT_OVERFLOW]        = overflow_q;
        statusWord[STAT_LEVEL_LO +: 8]   = (lvlWide > 32'd255) ? 8'hFF : lvlWide[7:0];
        changedWord                      = '0;
        changedWord[NCH-1:0]             = changed_q;
        case (sel)
            REG_OUT:     regWord = chOut;
            REG_IN:      regWord = chIn;
            REG_STATUS:  regWord = statusWord;
            REG_CHANGED: regWord = changedWord;
            REG_CYCLE:   regWord = cycle_q;
            default:     regWord = '0;
        endcase
        rdWord = regWord >> {addr[1:0], 3'b000};
    end

    // Change and overflow sets are OR-ed in after the W1C clear so they win.
    always_comb begin
        accept   = valid & ~ready_q;
        wrEn     = accept & write;
        be       = byteEnables(size, addr[1:0]);
        laneData = wdata << {addr[1:0], 3'b000};
        laneMask = byteMask(be);
        w1c      = laneData & laneMask;

        ready_d = accept;
        rdata_d = (accept && !write) ? rdWord : '0;

        for (int i = 0; i < NCH; i++) begin
            out_d[i]     = out_q[i];
            changeNow[i] = (inPrev_q[32*i +: 32] != in_vec[32*i +: 32]);
            if (wrEn && sel == REG_OUT && chIdx == 4'(i)) begin
                out_d[i] = (out_q[i] & ~laneMask) | (laneData & laneMask);
            end
        end

        changed_d = changed_q;
        if (wrEn && sel == REG_CHANGED) begin
            changed_d = changed_q & ~w1c[NCH-1:0];
        end
        changed_d = changed_d | changeNow;

        fifoPop  = ~fifoEmpty & tx_ready;
        fifoPush = wrEn && (sel == REG_TXDATA);

        overflow_d = overflow_q;
        if (wrEn && sel == REG_STATUS && w1c[STAT_OVERFLOW]) begin
            overflow_d = 1'b0;
        end
        if (fifoPush && fifoFull && !fifoPop) begin
            overflow_d = 1'b1;
        end

        cycle_d = (wrEn && sel == REG_CYCLE) ? '0 : cycle_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                out_q[i] <= '0;
            end
            inPrev_q   <= '0;
            changed_q  <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                out_q[i] <= out_d[i];
            end
            inPrev_q   <= in_vec;
            changed_q  <= changed_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

    debug_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifoPush),
        .data_i  (wdata[7:0]),
        .pop_i   (fifoPop),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign out_vec[32*g +: 32] = out_q[g];
    end

    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign tx_data  = fifoHead;
    assign tx_valid = ~fifoEmpty;

endmodule

// File: doc/debug_port.md
Name: debug_port

Overview:
- Parametrised successor to the single-pair debug register slave on the simple valid/ready memory bus.
- Provides NCH output/input register pairs, sticky change-detect on the inputs, byte/half/word sized writes, a free-running cycle counter and a byte TX FIFO draining to a console/host stream.
- Sits on the CPU data bus as a simulation/bring-up peripheral; tx_* connects to a testbench monitor or UART.

Parameters:
- NCH, 2, number of out/in register pairs (1..16)
- DEPTH, 8, TX FIFO depth in bytes (power of 2, 2..256)
- AW, 8, address bits decoded (upper addr bits ignored)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active high
- boot  in  1  boot strap, readable in STATUS
- in_vec  in  32*NCH  input channel i at bits [32i+31:32i]
- out_vec  out  32*NCH  output register i, same packing
- valid  in  1  bus request
- write  in  1  1 = write, 0 = read
- addr  in  32  byte address
- size  in  2  0 byte, 1 half, 2/3 word
- wdata  in  32  write data, right-aligned
- rdata  out  32  read data, right-aligned, valid while ready=1
- ready  out  1  one-cycle completion pulse
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO not empty
- tx_ready  in  1  consumer accepts head when tx_valid&tx_ready

Behaviour:
- Reset (async, rst=1): ready=0, rdata=0, out_vec=0, sticky bits=0, overflow=0, FIFO empty (tx_valid=0, tx_data=0), cycle counter=0.
- Accept: a transfer is accepted on a clk edge where valid=1 and ready=0. ready=1 on the following cycle only, then returns to 0. A master holding valid gets one transfer per two cycles. Exactly one side effect per accepted transfer.
- Write lanes:
  - lane data = wdata << 8*addr[1:0].
  - Byte enables = (size 0: 4'b0001, 1: 4'b0011, else 4'b1111) << addr[1:0], truncated to 4 bits.
  - Only enabled bytes of the target register update.
- Read: rdata registered at accept as (register >> 8*addr[1:0]). Unsized, so upper bytes may carry neighbour data. rdata is 0 for unmapped addresses and on any write.
- Address map (addr[AW-1:2]<<2):
  - 0x00+8i: OUT_i, RW
  - 0x04+8i: IN_i, RO, live in_vec sample
  - i < NCH only; other slots in 0x00..0x7C are unmapped.
  - 0x80 STATUS:
    - bit0 boot (RO)
    - bit1 tx_empty (RO)
    - bit2 tx_full (RO)
    - bit3 overflow (W1C)
    - [15:8] FIFO level (RO, saturating at 255)
  - 0x84 CHANGED [NCH-1:0]: sticky per-channel change flags, W1C.
  - 0x88 TXDATA, WO: write pushes wdata byte-lane-0 after lane shift (i.e. byte at addr[1:0]). Read returns 0.
  - 0x8C CYCLE: 32-bit free-running counter, +1 per clk, wraps 0xFFFFFFFF->0. Any write clears it to 0; it reads 1 the next cycle.
- Change detect: in_vec is registered each cycle; CHANGED[i] sets when the registered value differs from the current one. Set has priority over a same-cycle W1C clear.
- Overflow: a push when full with no same-cycle pop drops the byte and sets overflow. Set has priority over W1C.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full. Level is unchanged.
  - tx_data is the head entry, valid whenever tx_valid=1, with zero-cycle read (no bubble).
  - Pointers wrap modulo DEPTH; full/empty come from a level counter of width clog2(DEPTH)+1.
- Reset mid-transfer: ready drops immediately and the transfer is lost. A pending tx byte is lost.
- Unmapped write: ignored, ready still pulses.
- Simulation: under SIM, print out_vec changes and each popped tx byte as a character.

Decomposition:
- Package debug_pkg: address offsets (OFS_STATUS, OFS_CHANGED, OFS_TXDATA, OFS_CYCLE), size encodings, STATUS bit indices, byte-enable function.
- Sub-module debug_fifo (DEPTH, WIDTH=8): synchronous FIFO with push/pop/full/empty/level, same clk/rst.

Test Plan:
- Reset then read 0x00, 0x08, 0x80 with boot=1 -> rdata 0, 0, 0x00000003; out_vec=0; tx_valid=0.
- Write word 0x11223344 to 0x00, then byte 0xAA at 0x02 -> OUT_0=0x11AA3344. Half read at 0x02 -> rdata 0x000011AA.
- Set in_vec ch1 0->5 -> CHANGED=0x2. Write 0x2 to 0x84 in the same cycle in_vec ch1 changes again -> CHANGED stays 0x2. Clear on an idle cycle -> 0.
- tx_ready=0, DEPTH=8: push 9 bytes 'A'..'I' -> STATUS level=8, full=1, overflow=1. Raise tx_ready -> 'A'..'H' popped in order, 'I' absent, tx_valid falls after 8 cycles.
- Full FIFO, tx_ready=1, push in the same cycle -> byte accepted, overflow stays 0, level stays 8.
- Write 0x8C, then read 0x8C 10 cycles later -> value 10 ±1 per the documented capture point. Assert rst mid-read -> ready=0 immediately, counter 0.
